// File: rtl/irda_rx_pkg.sv
// Shared types and constants for the IrDA SIR receive controller.
// Optional build macro: IRDA_RX_PARITY_EN (adds one even-parity window before STOP).
package irda_rx_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

`ifdef IRDA_RX_PARITY_EN
    localparam int unsigned FRAME_EXTRA = 3;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
    localparam int unsigned FRAME_EXTRA = 2;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

    // Windows per frame: start + data (+ parity) + stop
    localparam int unsigned FRAME_LEN = DATA_BITS_DEF + FRAME_EXTRA;

endpackage

// File: rtl/irda_bit_cnt.sv
// Frame window counter: counts ended bit windows, flags the final window, wraps at terminal.
module irda_bit_cnt #(
    parameter int unsigned TERM = 10,
    parameter int unsigned CW   = $clog2(TERM + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          count,
    output logic [CW-1:0] bit_idx,
    output logic          bit_done
);

    // Window index; bit_done is high while the last window of the frame is open
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_idx  <= '0;
            bit_done <= 1'b0;
        end else if (clear) begin
            bit_idx  <= '0;
            bit_done <= 1'b0;
        end else if (count) begin
            if (bit_idx == CW'(TERM - 1)) begin
                bit_idx  <= '0;
                bit_done <= 1'b0;
            end else begin
                bit_idx  <= bit_idx + CW'(1);
                bit_done <= (bit_idx == CW'(TERM - 2));
            end
        end
    end

endmodule

// File: rtl/irda_rx_ctrl.sv
// IrDA SIR receive controller: start detection, 16x window timing, byte assembly,
// stop check and valid/ready delivery with framing/overrun flags.
// Optional build macro: IRDA_RX_PARITY_EN (parity window and parity_err output).
module irda_rx_ctrl
    import irda_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 baud_tick,
    input  logic                 ir_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef IRDA_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int unsigned TERM = DATA_BITS + FRAME_EXTRA;
    localparam int unsigned TW   = $clog2(OVERSAMPLE);
    localparam int unsigned CW   = $clog2(TERM + 1);

    rx_state_t            state;
    logic [2:0]           sync;
    logic [TW-1:0]        tick_cnt;
    logic                 pulse_seen;
    logic [DATA_BITS-1:0] shreg;
    logic [CW-1:0]        bit_idx;
    logic                 bit_done;
    logic                 pulse_edge;
    logic                 win_end;
    logic                 bit_val;
`ifdef IRDA_RX_PARITY_EN
    logic                 par_bit;
`endif

    assign pulse_edge = sync[1] & ~sync[2];
    assign win_end    = (state != IDLE) && baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));
    // A pulse edge coinciding with the window end still belongs to that window
    assign bit_val    = ~(pulse_seen | pulse_edge);

    irda_bit_cnt #(
        .TERM (TERM),
        .CW   (CW)
    ) u_bit_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    ((state == IDLE) || !enable),
        .count    (win_end),
        .bit_idx  (bit_idx),
        .bit_done (bit_done)
    );

    // Two-flop synchronizer plus one delay flop for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], ir_in};
        end
    end

    // Oversample tick counter and per-window pulse capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt   <= '0;
            pulse_seen <= 1'b0;
        end else if ((state == IDLE) || !enable) begin
            tick_cnt   <= '0;
            pulse_seen <= 1'b0;
        end else begin
            if (baud_tick) begin
                tick_cnt <= win_end ? '0 : tick_cnt + TW'(1);
            end
            if (win_end) begin
                pulse_seen <= 1'b0;
            end else if (pulse_edge) begin
                pulse_seen <= 1'b1;
            end
        end
    end

    // Frame FSM with byte assembly, delivery handshake and status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef IRDA_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef IRDA_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (!enable) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        shreg <= '0;
                        if (pulse_edge) begin
                            state <= START;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (win_end) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (win_end) begin
                            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                            if (bit_idx == CW'(DATA_BITS)) begin
`ifdef IRDA_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
`ifdef IRDA_RX_PARITY_EN
                    PARITY: begin
                        if (win_end) begin
                            par_bit <= bit_val;
                            state   <= STOP;
                        end
                    end
`endif
                    STOP: begin
                        if (win_end && bit_done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!bit_val) begin
                                frame_err <= 1'b1;
                            end else if (rx_valid && !rx_ready) begin
                                overrun <= 1'b1;
                            end else begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end
`ifdef IRDA_RX_PARITY_EN
                            parity_err <= ^{shreg, par_bit};
`endif
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irda_rx_ctrl.sv
// Testbench for irda_rx_ctrl: drives IrDA frames tick by tick and compares delivered
// bytes and status pulses against a transaction-level consumer model.
module tb_irda_rx_ctrl;

    localparam int unsigned DB = 8;
    localparam int unsigned TP = 8;
`ifdef IRDA_RX_PARITY_EN
    localparam int unsigned NW = DB + 3;
`else
    localparam int unsigned NW = DB + 2;
`endif
    localparam int unsigned NT = 16 * NW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          baud_tick;
    logic          ir_in;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef IRDA_RX_PARITY_EN
    logic          parity_err;
    bit            par_flip;
    int            exp_perr;
    int            obs_perr;
`endif

    int            tests;
    int            fails;
    bit            lvl [NT];
    logic [DB-1:0] exp_acc [$];
    logic [DB-1:0] obs_acc [$];
    int            exp_ferr;
    int            exp_ovr;
    int            obs_ferr;
    int            obs_ovr;
    bit            m_valid;
    logic [DB-1:0] m_data;

    irda_rx_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .baud_tick  (baud_tick),
        .ir_in      (ir_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef IRDA_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Observe accepted bytes and status pulses
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid && rx_ready) obs_acc.push_back(rx_data);
            if (frame_err) obs_ferr++;
            if (overrun) obs_ovr++;
`ifdef IRDA_RX_PARITY_EN
            if (parity_err) obs_perr++;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_tick(input bit ir);
        @(posedge clk); #1;
        baud_tick = 1'b1;
        ir_in     = ir;
        @(posedge clk); #1;
        baud_tick = 1'b0;
        repeat (TP - 2) @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0);
    endtask

    // Pulse pattern: start pulse at window begin, data/parity/stop pulses mid-window
    task automatic build(input logic [DB-1:0] b, input bit stop_p);
        bit pulse [NW];
        pulse[0] = 1'b1;
        for (int i = 0; i < DB; i++) pulse[1+i] = ~b[i];
`ifdef IRDA_RX_PARITY_EN
        pulse[DB+1] = ~((^b) ^ par_flip);
`endif
        pulse[NW-1] = stop_p;
        for (int k = 0; k < NW; k++) begin
            for (int p = 0; p < 16; p++) begin
                lvl[16*k+p] = pulse[k] && ((k == 0) ? (p < 3) : (p >= 5 && p < 8));
            end
        end
    endtask

    // Consumer-side outcome of one completed frame
    task automatic model_frame(input logic [DB-1:0] b, input bit stop_p);
        if (stop_p) exp_ferr++;
        else if (rx_ready) exp_acc.push_back(b);
        else if (m_valid) exp_ovr++;
        else begin
            m_valid = 1'b1;
            m_data  = b;
        end
`ifdef IRDA_RX_PARITY_EN
        if (par_flip) exp_perr++;
`endif
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input bit stop_p);
        build(b, stop_p);
        for (int j = 0; j < NT; j++) do_tick(lvl[j]);
        model_frame(b, stop_p);
    endtask

    task automatic release_ready();
        rx_ready = 1'b1;
        if (m_valid) begin
            exp_acc.push_back(m_data);
            m_valid = 1'b0;
        end
    endtask

    task automatic check_sb(input string tag);
        chk({tag, "_nbytes"}, obs_acc.size(), exp_acc.size());
        for (int i = 0; i < exp_acc.size() && i < obs_acc.size(); i++)
            chk({tag, "_byte"}, 32'(obs_acc[i]), 32'(exp_acc[i]));
        chk({tag, "_frame_err"}, obs_ferr, exp_ferr);
        chk({tag, "_overrun"}, obs_ovr, exp_ovr);
`ifdef IRDA_RX_PARITY_EN
        chk({tag, "_parity_err"}, obs_perr, exp_perr);
`endif
    endtask

    initial begin
        logic [DB-1:0] b;
        bit            sp;
        tests = 0; fails = 0;
        exp_ferr = 0; exp_ovr = 0; obs_ferr = 0; obs_ovr = 0;
        m_valid = 1'b0; m_data = '0;
`ifdef IRDA_RX_PARITY_EN
        par_flip = 1'b0; exp_perr = 0; obs_perr = 0;
`endif
        reset_n = 1'b0; enable = 1'b1; ir_in = 1'b0; baud_tick = 1'b0; rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        idle(2);

        // Basic byte
        send_frame(8'hA5, 1'b0);
        idle(3);
        check_sb("a5");

        // Pulse in stop window
        send_frame(8'h3C, 1'b1);
        idle(3);
        @(negedge clk);
        chk("stop_err_busy", 32'(busy), 0);
        chk("stop_err_valid", 32'(rx_valid), 0);
        check_sb("stop_err");

        // Held byte then overrun
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        do_tick(1'b0);
        send_frame(8'h22, 1'b0);
        idle(3);
        @(negedge clk);
        chk("held_valid", 32'(rx_valid), 1);
        chk("held_data", 32'(rx_data), 32'h11);
        check_sb("overrun");
        @(posedge clk); #1;
        release_ready();
        repeat (2) @(negedge clk);
        chk("accept_valid_fall", 32'(rx_valid), 0);
        check_sb("accept");

        // Abort during data bit 4
        b = 8'($urandom);
        build(b, 1'b0);
        for (int j = 0; j < 16 * 5 + 8; j++) do_tick(lvl[j]);
        @(posedge clk); #1;
        chk("abort_busy_before", 32'(busy), 1);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 0);
        enable = 1'b1;
        idle(4);
        check_sb("abort");
        send_frame(8'hFF, 1'b0);
        idle(3);
        check_sb("after_abort");

        // Back-to-back frames
        send_frame(8'h00, 1'b0);
        do_tick(1'b0);
        send_frame(8'hFF, 1'b0);
        idle(3);
        check_sb("b2b");

        // Random frames with occasional stop errors and varied gaps
        for (int n = 0; n < 6; n++) begin
            b  = 8'($urandom);
            sp = ($urandom_range(0, 3) == 0);
            send_frame(b, sp);
            idle(1 + $urandom_range(0, 2));
        end
        idle(2);
        check_sb("random");

`ifdef IRDA_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h07, 1'b0);
        idle(3);
        check_sb("parity_bad");
        par_flip = 1'b0;
        send_frame(8'h07, 1'b0);
        idle(3);
        check_sb("parity_good");
`endif

        // Asynchronous reset mid-frame
        b = 8'($urandom);
        build(b, 1'b0);
        for (int j = 0; j < 40; j++) do_tick(lvl[j]);
        @(posedge clk); #1;
        chk("mid_busy_before", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("areset_busy", 32'(busy), 0);
        chk("areset_rx_data", 32'(rx_data), 0);
        chk("areset_rx_valid", 32'(rx_valid), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(3);
        check_sb("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/irda_rx_ctrl.md
Name: irda_rx_ctrl

Overview:
- Receive-side controller for the IrDA SIR receiver (RXD_V2): detects start pulses, times bit windows at 16x oversampling, sequences the 10-bit frame bit counter, assembles the byte and checks the stop bit.
- Sits between the IR photodiode input and the UART-side byte consumer. Output is a valid/ready byte interface with framing and overrun flags.
- IrDA coding: a pulse within a bit window means 0; no pulse means 1.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit window (min 4).
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  receiver enable; low aborts any frame in progress
- baud_tick  in  1  one-clk strobe at OVERSAMPLE x bit rate
- ir_in  in  1  raw IR pulse input, active high, asynchronous
- rx_data  out  DATA_BITS  received byte, stable while rx_valid=1
- rx_valid  out  1  byte available
- rx_ready  in  1  consumer accepts byte when rx_valid and rx_ready are both 1
- frame_err  out  1  one-clk pulse: pulse seen in stop window
- overrun  out  1  one-clk pulse: frame completed while previous byte was still held
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, all counters=0, synchronizer flops=0.
- Input conditioning:
  - ir_in passes through a 2-flop synchronizer.
  - pulse_edge = rising edge of the synchronized signal (3-clk latency from pin).
- Bit counter: sub-module with count, clear and bit_done; bit_done at terminal count DATA_BITS+2.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On pulse_edge with enable=1, go to START.
  - Clear tick_cnt, pulse_seen, shift register and bit counter.
- Window timing (all non-IDLE states):
  - tick_cnt increments on baud_tick.
  - Window ends on the baud_tick where tick_cnt==OVERSAMPLE-1; tick_cnt then returns to 0.
  - At each window end, pulse count=1 to the bit counter.
- pulse_seen:
  - Set by pulse_edge during a window.
  - Cleared at each window end, except that an edge in the same cycle as the window end counts toward the ending window.
  - The start pulse itself does not set pulse_seen.
- START: at window end, go to DATA.
- DATA:
  - At each window end, shift in bit = ~pulse_seen at MSB with right shift, so the result is LSB first.
  - After DATA_BITS windows, go to STOP.
- STOP window end:
  - If pulse_seen=1: frame_err=1 for one clk, byte discarded.
  - Otherwise deliver the byte (see handshake); go to IDLE either way.
  - A pulse_edge in that same cycle is ignored; the next start is detected from the following cycle.
- Handshake and latency:
  - Delivery: rx_data and rx_valid update on the clk after the STOP-ending baud_tick.
  - rx_valid is held until accepted; rx_data does not change while rx_valid=1.
  - Delivery while rx_valid=1 and no acceptance that cycle: overrun=1 for one clk, new byte dropped, old byte retained.
  - Delivery in the same cycle as an acceptance: new byte loads, rx_valid stays 1, no overrun.
- enable=0 mid-frame: next clk goes to IDLE, partial byte discarded, no flags; rx_valid/rx_data unaffected.
- Async reset mid-frame: immediate return to reset values.
- baud_tick must not occur on consecutive clks; no special handling is required.

Optional Feature:
- Macro: IRDA_RX_PARITY_EN.
- Defined:
  - One even-parity window is inserted between the last DATA window and STOP; the bit counter terminal count becomes DATA_BITS+3.
  - Adds output parity_err (1 bit), a one-clk pulse at STOP end when the XOR of data bits and the parity bit is 1. The byte is still delivered.
  - parity_err resets to 0.
- Undefined: no parity window, no parity_err port.

Decomposition:
- Package irda_rx_pkg:
  - state enum (IDLE, START, DATA, STOP, plus PARITY under the macro)
  - default OVERSAMPLE and DATA_BITS constants
  - frame length constant: DATA_BITS+2, or +3 under the macro
- Sub-module irda_bit_cnt: frame bit counter with clk, reset_n, clear, count, bit_done, parameterised terminal count, asynchronous active-low reset, wrap to 0 on count at terminal.
- FSM, synchronizer, tick counter, shift register and handshake are all inside irda_rx_ctrl.

Test Plan:
- Send 0xA5 (OVERSAMPLE=16, one pulse per 0-bit, 3-tick wide pulses, no pulse in stop), rx_ready=1 -> rx_valid one clk with rx_data=0xA5, frame_err=0.
- Send 0x3C with a pulse injected in the stop window -> frame_err pulse, rx_valid stays 0, FSM returns to IDLE.
- Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 held, overrun pulse at second frame end; rx_ready=1 then gives one accept and rx_valid falls.
- Deassert enable mid-DATA at bit 4 -> IDLE within 1 clk, no rx_valid; next full frame 0xFF is received correctly.
- Back-to-back 0x00 and 0xFF, with the next start pulse one tick after the STOP window -> both bytes received in order.
- IRDA_RX_PARITY_EN defined: send 0x07 with wrong parity -> rx_data=0x07 delivered, parity_err pulse. Repeat with correct parity -> no parity_err.
